// File: rtl/frwd_sb_if.sv
// Operand-forwarding bus between decode/EX control and the frwd_sb scoreboard.
interface frwd_sb_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RA_W  = 5,
   parameter int unsigned NPORT = 2,
   parameter int unsigned DEPTH = 3
);
   logic                     i_advance;
   logic                     i_flush;
   logic                     i_iss_valid;
   logic                     i_iss_we;
   logic                     i_iss_load;
   logic [RA_W-1:0]          i_iss_rd;
   logic [NPORT-1:0]         i_rs_used;
   logic [NPORT*RA_W-1:0]    i_rs_addr;
   logic [NPORT*XLEN-1:0]    i_rs_rdata;
   logic [DEPTH*XLEN-1:0]    i_stg_data;
   logic [NPORT*XLEN-1:0]    o_op;
   logic [NPORT-1:0]         o_fwd_hit;
   logic                     o_stall;
   logic [31:0]              o_stall_cnt;

   modport master (
      output i_advance, i_flush, i_iss_valid, i_iss_we, i_iss_load, i_iss_rd,
             i_rs_used, i_rs_addr, i_rs_rdata, i_stg_data,
      input  o_op, o_fwd_hit, o_stall, o_stall_cnt
   );

   modport slave (
      input  i_advance, i_flush, i_iss_valid, i_iss_we, i_iss_load, i_iss_rd,
             i_rs_used, i_rs_addr, i_rs_rdata, i_stg_data,
      output o_op, o_fwd_hit, o_stall, o_stall_cnt
   );
endinterface

// File: rtl/frwd_sb.sv
// Forwarding unit with an in-flight destination scoreboard: picks the youngest
// matching producer per read port and raises a load-use stall when its data
// is not yet available.
module frwd_sb #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned RA_W        = 5,
   parameter int unsigned NPORT       = 2,
   parameter int unsigned DEPTH       = 3,
   parameter int unsigned LOAD_RDY    = 1,
   parameter int unsigned FLUSH_DEPTH = 1,
   // reset value of the stall counter; nonzero only to reach saturation quickly
   parameter logic [31:0] CNT_RST     = 32'h0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   frwd_sb_if.slave    sb_if
);

   logic [DEPTH-1:0]      r_vld;
   logic [DEPTH-1:0]      r_we;
   logic [DEPTH-1:0]      r_ld;
   logic [RA_W-1:0]       r_rd [DEPTH];
   logic [31:0]           r_stall_cnt;

   logic [DEPTH-1:0]      w_keep;
   logic [DEPTH-1:0]      w_vld_n;
   logic [DEPTH-1:0]      w_we_n;
   logic [DEPTH-1:0]      w_ld_n;
   logic [RA_W-1:0]       w_rd_n [DEPTH];
   logic                  w_shift;
   logic                  w_ins;

   logic [NPORT*XLEN-1:0] w_op;
   logic [NPORT-1:0]      w_hit;
   logic [NPORT-1:0]      w_found;
   logic                  w_stall_raw;
   logic                  w_stall;

   // Per-port lookup: first match walking from EX (k=0) outward is the youngest.
   always_comb begin
      w_op        = sb_if.i_rs_rdata;
      w_hit       = '0;
      w_found     = '0;
      w_stall_raw = 1'b0;
      for (int unsigned p = 0; p < NPORT; p++) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!w_found[p] && sb_if.i_rs_used[p] &&
                (sb_if.i_rs_addr[p*RA_W +: RA_W] != '0) &&
                r_vld[k] && r_we[k] &&
                (r_rd[k] == sb_if.i_rs_addr[p*RA_W +: RA_W])) begin
               w_found[p] = 1'b1;
               if (!r_ld[k] || (k >= LOAD_RDY)) begin
                  w_op[p*XLEN +: XLEN] = sb_if.i_stg_data[k*XLEN +: XLEN];
                  w_hit[p]             = 1'b1;
               end else begin
                  w_stall_raw = 1'b1;
               end
            end
         end
      end
   end

   // A redirect squashes the stalled consumer, so the stall is dropped.
   assign w_stall = w_stall_raw & ~sb_if.i_flush;

   // Next scoreboard contents: flush > freeze > bubble on stall > normal issue.
   always_comb begin
      w_shift = 1'b0;
      w_ins   = 1'b0;
      w_keep  = r_vld;
      if (sb_if.i_flush) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (k < FLUSH_DEPTH) begin
               w_keep[k] = 1'b0;
            end
         end
         w_shift = sb_if.i_advance;
      end else if (sb_if.i_advance) begin
         w_shift = 1'b1;
         w_ins   = sb_if.i_iss_valid & ~w_stall;
      end
      w_vld_n = w_keep;
      w_we_n  = r_we;
      w_ld_n  = r_ld;
      w_rd_n  = r_rd;
      if (w_shift) begin
         for (int unsigned k = 1; k < DEPTH; k++) begin
            w_vld_n[k] = w_keep[k-1];
            w_we_n[k]  = r_we[k-1];
            w_ld_n[k]  = r_ld[k-1];
            w_rd_n[k]  = r_rd[k-1];
         end
         w_vld_n[0] = w_ins;
         w_we_n[0]  = sb_if.i_iss_we;
         w_ld_n[0]  = sb_if.i_iss_load;
         w_rd_n[0]  = sb_if.i_iss_rd;
      end
   end

   // Scoreboard state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld <= '0;
         r_we  <= '0;
         r_ld  <= '0;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            r_rd[k] <= '0;
         end
      end else begin
         r_vld <= w_vld_n;
         r_we  <= w_we_n;
         r_ld  <= w_ld_n;
         r_rd  <= w_rd_n;
      end
   end

   // Saturating count of cycles the pipeline actually spent stalled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_cnt <= CNT_RST;
      end else if (w_stall && sb_if.i_advance && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign sb_if.o_op        = w_op;
   assign sb_if.o_fwd_hit   = w_hit;
   assign sb_if.o_stall     = w_stall;
   assign sb_if.o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_frwd_sb.sv
// Scoreboard bench for frwd_sb: a default instance and a 3-port / 4-deep /
// LOAD_RDY=2 instance whose stall counter starts near saturation.
module tb_frwd_sb;

   localparam logic [31:0] R0 = 32'h1111_1111;
   localparam logic [31:0] R1 = 32'h2222_2222;
   localparam logic [31:0] R2 = 32'h3333_3333;
   localparam logic [31:0] FE = 32'hFFFF_FFFE;
   localparam logic [31:0] FF = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   frwd_sb_if #(.XLEN(32), .RA_W(5), .NPORT(2), .DEPTH(3)) b0 ();
   frwd_sb_if #(.XLEN(32), .RA_W(5), .NPORT(3), .DEPTH(4)) b1 ();

   frwd_sb #(.XLEN(32), .RA_W(5), .NPORT(2), .DEPTH(3), .LOAD_RDY(1),
             .FLUSH_DEPTH(1), .CNT_RST(32'h0)) u_dut0 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .sb_if   (b0)
   );

   frwd_sb #(.XLEN(32), .RA_W(5), .NPORT(3), .DEPTH(4), .LOAD_RDY(2),
             .FLUSH_DEPTH(1), .CNT_RST(32'hFFFF_FFFE)) u_dut1 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .sb_if   (b1)
   );

   typedef struct packed {
      logic        inst;
      logic [95:0] op;
      logic [2:0]  hit;
      logic        st;
      logic [31:0] cnt;
   } exp_t;

   exp_t  sb_q [$];
   string tag_q [$];
   int    n_chk = 0;
   int    n_err = 0;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Pop every expectation queued this cycle and compare against the DUT.
   always @(negedge clk) begin
      exp_t  e;
      string t;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         t = tag_q.pop_front();
         if (e.inst == 1'b0) begin
            chk({t, ".op"},  96'(b0.o_op),        e.op);
            chk({t, ".hit"}, 96'(b0.o_fwd_hit),   96'(e.hit));
            chk({t, ".stl"}, 96'(b0.o_stall),     96'(e.st));
            chk({t, ".cnt"}, 96'(b0.o_stall_cnt), 96'(e.cnt));
         end else begin
            chk({t, ".op"},  96'(b1.o_op),        e.op);
            chk({t, ".hit"}, 96'(b1.o_fwd_hit),   96'(e.hit));
            chk({t, ".stl"}, 96'(b1.o_stall),     96'(e.st));
            chk({t, ".cnt"}, 96'(b1.o_stall_cnt), 96'(e.cnt));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic iss0(input logic v, input logic we, input logic ld, input logic [4:0] rd);
      b0.i_iss_valid = v;
      b0.i_iss_we    = we;
      b0.i_iss_load  = ld;
      b0.i_iss_rd    = rd;
   endtask

   task automatic iss1(input logic v, input logic we, input logic ld, input logic [4:0] rd);
      b1.i_iss_valid = v;
      b1.i_iss_we    = we;
      b1.i_iss_load  = ld;
      b1.i_iss_rd    = rd;
   endtask

   task automatic rd0(input logic [1:0] used, input logic [4:0] a1, input logic [4:0] a0);
      b0.i_rs_used = used;
      b0.i_rs_addr = {a1, a0};
   endtask

   task automatic rd1(input logic [2:0] used, input logic [4:0] a2, input logic [4:0] a1,
                      input logic [4:0] a0);
      b1.i_rs_used = used;
      b1.i_rs_addr = {a2, a1, a0};
   endtask

   task automatic ex0(input string tag, input logic [31:0] op0, input logic [31:0] op1,
                      input logic [1:0] hit, input logic st, input logic [31:0] cnt);
      exp_t e;
      e.inst = 1'b0;
      e.op   = {32'h0, op1, op0};
      e.hit  = {1'b0, hit};
      e.st   = st;
      e.cnt  = cnt;
      sb_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic ex1(input string tag, input logic [31:0] op0, input logic [31:0] op1,
                      input logic [31:0] op2, input logic [2:0] hit, input logic st,
                      input logic [31:0] cnt);
      exp_t e;
      e.inst = 1'b1;
      e.op   = {op2, op1, op0};
      e.hit  = hit;
      e.st   = st;
      e.cnt  = cnt;
      sb_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      b0.i_advance = 1'b1; b0.i_flush = 1'b0;
      iss0(1'b0, 1'b0, 1'b0, 5'd0); rd0(2'b00, 5'd0, 5'd0);
      b0.i_rs_rdata = {R1, R0};
      b0.i_stg_data = {32'h99, 32'hCAFE, 32'h11};
      b1.i_advance = 1'b1; b1.i_flush = 1'b0;
      iss1(1'b0, 1'b0, 1'b0, 5'd0); rd1(3'b000, 5'd0, 5'd0, 5'd0);
      b1.i_rs_rdata = {R2, R1, R0};
      b1.i_stg_data = {32'h40, 32'h30, 32'h20, 32'h10};
      #1;
      ex0("rst0", R0, R1, 2'b00, 1'b0, 32'd0);
      ex1("rst1", R0, R1, R2, 3'b000, 1'b0, FE);
      @(negedge clk); #1; rst_n = 1'b1;

      // ALU RAW through every stage, then retire
      cyc(); iss0(1'b1, 1'b1, 1'b0, 5'd5); ex0("alu_iss", R0, R1, 2'b00, 1'b0, 32'd0);
      cyc(); iss0(1'b0, 1'b0, 1'b0, 5'd0); rd0(2'b01, 5'd0, 5'd5);
             ex0("alu_k0", 32'h11, R1, 2'b01, 1'b0, 32'd0);
      cyc(); ex0("alu_k1", 32'hCAFE, R1, 2'b01, 1'b0, 32'd0);
      cyc(); ex0("alu_k2", 32'h99, R1, 2'b01, 1'b0, 32'd0);
      cyc(); ex0("alu_ret", R0, R1, 2'b00, 1'b0, 32'd0);

      // load-use: one stall cycle, issue during stall is dropped
      cyc(); rd0(2'b00, 5'd0, 5'd0); iss0(1'b1, 1'b1, 1'b1, 5'd7);
             ex0("ld_iss", R0, R1, 2'b00, 1'b0, 32'd0);
      cyc(); iss0(1'b1, 1'b1, 1'b0, 5'd12); rd0(2'b10, 5'd7, 5'd0);
             ex0("ld_stall", R0, R1, 2'b00, 1'b1, 32'd0);
      cyc(); iss0(1'b0, 1'b0, 1'b0, 5'd0); rd0(2'b11, 5'd7, 5'd12);
             ex0("ld_fwd", R0, 32'hCAFE, 2'b10, 1'b0, 32'd1);

      // youngest producer wins
      cyc(); rd0(2'b00, 5'd0, 5'd0); iss0(1'b1, 1'b1, 1'b0, 5'd3);
             ex0("yw_iss0", R0, R1, 2'b00, 1'b0, 32'd1);
      cyc(); ex0("yw_iss1", R0, R1, 2'b00, 1'b0, 32'd1);
      cyc(); iss0(1'b0, 1'b0, 1'b0, 5'd0); b0.i_stg_data = {32'h99, 32'hA, 32'hB};
             rd0(2'b11, 5'd0, 5'd3); ex0("yw_k0", 32'hB, R1, 2'b01, 1'b0, 32'd1);
      cyc(); iss0(1'b1, 1'b1, 1'b1, 5'd4); rd0(2'b01, 5'd0, 5'd3);
             ex0("yw_k1", 32'hA, R1, 2'b01, 1'b0, 32'd1);
      cyc(); iss0(1'b1, 1'b1, 1'b1, 5'd9); b0.i_stg_data = {32'h99, 32'hCAFE, 32'h11};
             rd0(2'b00, 5'd4, 5'd4); ex0("unused", R0, R1, 2'b00, 1'b0, 32'd1);

      // flush squashes entry 0, older entries keep moving
      cyc(); iss0(1'b1, 1'b1, 1'b0, 5'd20); b0.i_flush = 1'b1; rd0(2'b01, 5'd0, 5'd9);
             ex0("flush", R0, R1, 2'b00, 1'b0, 32'd1);
      cyc(); b0.i_flush = 1'b0; iss0(1'b0, 1'b0, 1'b0, 5'd0); rd0(2'b11, 5'd4, 5'd9);
             ex0("flush_kept", R0, 32'h99, 2'b10, 1'b0, 32'd1);

      // freeze holds entries and counter
      cyc(); rd0(2'b00, 5'd0, 5'd0); iss0(1'b1, 1'b1, 1'b1, 5'd9);
             ex0("frz_iss", R0, R1, 2'b00, 1'b0, 32'd1);
      cyc(); iss0(1'b0, 1'b0, 1'b0, 5'd0); b0.i_advance = 1'b0; rd0(2'b01, 5'd0, 5'd9);
             ex0("frz0", R0, R1, 2'b00, 1'b1, 32'd1);
      cyc(); ex0("frz1", R0, R1, 2'b00, 1'b1, 32'd1);
      cyc(); ex0("frz2", R0, R1, 2'b00, 1'b1, 32'd1);
      cyc(); b0.i_advance = 1'b1; ex0("frz_rel", R0, R1, 2'b00, 1'b1, 32'd1);
      cyc(); ex0("frz_fwd", 32'hCAFE, R1, 2'b01, 1'b0, 32'd2);

      // asynchronous reset while a stall is pending
      cyc(); rd0(2'b00, 5'd0, 5'd0); iss0(1'b1, 1'b1, 1'b1, 5'd6);
             ex0("rst_pre_iss", R0, R1, 2'b00, 1'b0, 32'd2);
      cyc(); iss0(1'b0, 1'b0, 1'b0, 5'd0); rd0(2'b01, 5'd0, 5'd6);
             ex0("rst_pre", R0, R1, 2'b00, 1'b1, 32'd2);
      @(negedge clk); #1; b0.i_advance = 1'b0;
      cyc(); rst_n = 1'b0;
             ex0("rst_async", R0, R1, 2'b00, 1'b0, 32'd0);
             ex1("rst_async1", R0, R1, R2, 3'b000, 1'b0, FE);
      @(negedge clk); #1; rst_n = 1'b1; b0.i_advance = 1'b1;
      cyc(); ex0("rst_clr", R0, R1, 2'b00, 1'b0, 32'd0);

      // 3 ports, 4 entries, load data valid from entry 2
      cyc(); iss1(1'b1, 1'b1, 1'b0, 5'd5); ex1("p3_iss", R0, R1, R2, 3'b000, 1'b0, FE);
      cyc(); iss1(1'b0, 1'b0, 1'b0, 5'd0); rd1(3'b100, 5'd5, 5'd0, 5'd0);
             ex1("p3_k0", R0, R1, 32'h10, 3'b100, 1'b0, FE);
      cyc(); ex1("p3_k1", R0, R1, 32'h20, 3'b100, 1'b0, FE);
      cyc(); ex1("p3_k2", R0, R1, 32'h30, 3'b100, 1'b0, FE);
      cyc(); ex1("p3_k3", R0, R1, 32'h40, 3'b100, 1'b0, FE);
      cyc(); ex1("p3_ret", R0, R1, R2, 3'b000, 1'b0, FE);
      cyc(); rd1(3'b000, 5'd0, 5'd0, 5'd0); iss1(1'b1, 1'b1, 1'b1, 5'd7);
             ex1("p3_ld_iss", R0, R1, R2, 3'b000, 1'b0, FE);
      cyc(); iss1(1'b0, 1'b0, 1'b0, 5'd0); rd1(3'b010, 5'd0, 5'd7, 5'd0);
             ex1("p3_ld_s0", R0, R1, R2, 3'b000, 1'b1, FE);
      cyc(); ex1("p3_ld_s1", R0, R1, R2, 3'b000, 1'b1, FF);
      cyc(); iss1(1'b1, 1'b1, 1'b1, 5'd8);
             ex1("p3_ld_fwd", R0, 32'h30, R2, 3'b010, 1'b0, FF);
      cyc(); iss1(1'b0, 1'b0, 1'b0, 5'd0); rd1(3'b010, 5'd0, 5'd8, 5'd0);
             ex1("p3_sat_s0", R0, R1, R2, 3'b000, 1'b1, FF);
      cyc(); ex1("p3_sat_s1", R0, R1, R2, 3'b000, 1'b1, FF);
      cyc(); ex1("p3_sat_fwd", R0, 32'h30, R2, 3'b010, 1'b0, FF);

      @(negedge clk); #1;
      chk("sb_drain", 96'(sb_q.size()), 96'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
